// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, seven-segment
// codes (active-low {dp,g,f,e,d,c,b,a}) and the BCD digit increment helper.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Returns {carry_out, next_digit}; 9 wraps to 0 with a carry.
    function automatic logic [4:0] bcd_digit_inc(input logic [3:0] digit);
        if (digit >= 4'd9) begin
            return 5'b1_0000;
        end
        return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 4-digit seven-segment driver: free-running scan counter picks a
// digit, which is decoded and registered together with its anode enable.
module seg7_scan
    import score_pkg::*;
#(
    parameter int SCAN_DIV_BITS = 17
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] value,
    output logic [3:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam logic [SCAN_DIV_BITS-1:0] SCAN_ONE = 1;

    logic [SCAN_DIV_BITS-1:0] scan_cnt;
    logic [1:0]               idx;
    logic [3:0]               digit;
    logic [7:0]               code;

    assign idx = scan_cnt[SCAN_DIV_BITS-1 -: 2];

    always_comb begin
        digit = value[3:0];
        case (idx)
            2'd0: digit = value[3:0];
            2'd1: digit = value[7:4];
            2'd2: digit = value[11:8];
            2'd3: digit = value[15:12];
            default: digit = value[3:0];
        endcase
    end

    // Non-BCD nibbles can only appear through misuse; show them blank.
    always_comb begin
        code = SEG_BLANK;
        case (digit)
            4'd0: code = SEG_0;
            4'd1: code = SEG_1;
            4'd2: code = SEG_2;
            4'd3: code = SEG_3;
            4'd4: code = SEG_4;
            4'd5: code = SEG_5;
            4'd6: code = SEG_6;
            4'd7: code = SEG_7;
            4'd8: code = SEG_8;
            4'd9: code = SEG_9;
            default: code = SEG_BLANK;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            scan_cnt <= '0;
            seg_an   <= 4'b1111;
            seg_cat  <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_cnt + SCAN_ONE;
            seg_an   <= ~(4'b0001 << idx);
            seg_cat  <= code;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game scoring: counts frames while a game runs, accumulates a saturating BCD
// score, keeps the session high score and drives the seven-segment display.
module score_keeper
    import score_pkg::*;
#(
    parameter int FRAMES_PER_POINT = 6,
    parameter int SCAN_DIV_BITS    = 17
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        fresh,
    input  logic        game_status,
    input  logic        show_high,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        new_record,
    output logic [3:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_POINT - 1);

    state_t      state;
    logic        fresh_q;
    logic        gs_q;
    logic [7:0]  frame_cnt;
    logic        tick;
    logic        rise;
    logic        fall;
    logic [15:0] score_inc;
    logic        carry;
    logic [4:0]  digit_inc;
    logic [15:0] display_val;

    assign tick = fresh_q & ~fresh;
    assign rise = game_status & ~gs_q;
    assign fall = ~game_status & gs_q;

    // Ripple the +1 through the four BCD digits, stopping once a digit absorbs it.
    always_comb begin
        score_inc = score;
        carry     = 1'b1;
        digit_inc = '0;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                digit_inc          = bcd_digit_inc(score[4*i +: 4]);
                score_inc[4*i +: 4] = digit_inc[3:0];
                carry              = digit_inc[4];
            end
        end
    end

    // Transitions take priority over tick, so a coincident frame tick is dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            fresh_q    <= 1'b1;
            gs_q       <= 1'b0;
            frame_cnt  <= '0;
            score      <= '0;
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            fresh_q <= fresh;
            gs_q    <= game_status;
            case (state)
                IDLE, OVER: begin
                    if (rise) begin
                        state      <= RUN;
                        score      <= '0;
                        frame_cnt  <= '0;
                        new_record <= 1'b0;
                    end
                end
                RUN: begin
                    if (fall) begin
                        state <= OVER;
                        if (score > high_score) begin
                            high_score <= score;
                            new_record <= 1'b1;
                        end
                    end else if (tick) begin
                        if (frame_cnt == LAST_FRAME) begin
                            frame_cnt <= '0;
                            if (score != 16'h9999) begin
                                score <= score_inc;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign display_val = show_high ? high_score : score;

    seg7_scan #(
        .SCAN_DIV_BITS(SCAN_DIV_BITS)
    ) u_scan (
        .CLK    (CLK),
        .RESET  (RESET),
        .value  (display_val),
        .seg_an (seg_an),
        .seg_cat(seg_cat)
    );

endmodule
